serial_word_feeder: RTL and testbench

//  Word buffer sitting directly upstream of the serial controller (serial.sv).

---
 rtl/serial_pkg.sv | 10 +
 rtl/serial_word_feeder_ringbuf.sv | 68 ++++++
 rtl/serial_word_feeder.sv | 109 ++++++++++
 tb/tb_serial_word_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial word feeder and its ring buffer.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } t_feeder_state;

endpackage

// File: rtl/serial_word_feeder_ringbuf.sv
// Word storage for the feeder: power-of-two ring with level-based full/empty
// and a registered head word that is zero whenever the buffer is empty.
module ringbuf #(
  parameter int BITS      = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [BITS-1:0]      wr_data,
  output logic [BITS-1:0]      rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level
);

  logic [BITS-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic [BITS-1:0]      head_q, head_d;

  assign full    = (level_q == (ADDR_BITS+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = head_q;

  // Strobes arrive pre-qualified by the feeder; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en) level_d = level_q + (ADDR_BITS+1)'(1);
    else if (rd_en && !wr_en) level_d = level_q - (ADDR_BITS+1)'(1);
  end

  // The head register looks ahead so a word written this cycle can become head.
  always_comb begin
    head_d = '0;
    if (level_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
      else                                 head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Host-facing word FIFO feeding the serial controller: presents the head word,
// pops on each next-word rising edge and captures the word received meanwhile.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_wr,
  input  logic [BITS-1:0]      in_wr_data,
  output logic                 out_full,
  output logic                 out_empty,
  output logic [ADDR_BITS:0]   out_level,
  output logic                 out_overflow,
  output logic [BITS-1:0]      out_parallel,
  output logic                 out_enable,
  input  logic                 in_next_word,
  input  logic                 in_ready,
  input  logic [BITS-1:0]      in_rx_parallel,
  output logic [BITS-1:0]      out_rx_data,
  output logic                 out_rx_valid
);

  t_feeder_state   state_q, state_d;
  logic            enable_q, enable_d;
  logic            next_prev_q, next_prev_d;
  logic [BITS-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overflow_q, overflow_d;
  logic            pop_edge, wr_ok, pop_ok;

  ringbuf #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) u_ringbuf (
    .clk     (in_clk),
    .rst_n   (in_rst),
    .wr_en   (wr_ok),
    .rd_en   (pop_ok),
    .wr_data (in_wr_data),
    .rd_data (out_parallel),
    .full    (out_full),
    .empty   (out_empty),
    .level   (out_level)
  );

  assign out_enable   = enable_q;
  assign out_rx_data  = rx_data_q;
  assign out_rx_valid = rx_valid_q;
  assign out_overflow = overflow_q;

  // A pop edge on an empty FIFO still captures the received word.
  always_comb begin
    pop_edge    = in_next_word & ~next_prev_q;
    wr_ok       = in_wr & ~out_full;
    pop_ok      = pop_edge & ~out_empty;
    next_prev_d = in_next_word;
    rx_valid_d  = pop_edge;
    rx_data_d   = pop_edge ? in_rx_parallel : rx_data_q;
    overflow_d  = in_wr & out_full;
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    unique case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (!out_empty && in_ready) begin
          state_d  = RUN;
          enable_d = 1'b1;
        end
      end
      RUN: begin
        if (pop_ok && !wr_ok && (out_level == (ADDR_BITS+1)'(1))) begin
          state_d  = DRAIN;
          enable_d = 1'b0;
        end
      end
      DRAIN: begin
        enable_d = 1'b0;
        if (in_ready) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      next_prev_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      next_prev_q <= next_prev_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder (BITS=8, DEPTH=4) with the serial
// controller emulated by driving in_next_word / in_rx_parallel from tasks.
`timescale 1ns/1ps
module tb_serial_word_feeder;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int AB    = $clog2(DEPTH);

  logic            in_clk = 1'b0;
  logic            in_rst;
  logic            in_wr;
  logic [BITS-1:0] in_wr_data;
  logic            out_full, out_empty, out_overflow, out_enable;
  logic [AB:0]     out_level;
  logic [BITS-1:0] out_parallel;
  logic            in_next_word, in_ready;
  logic [BITS-1:0] in_rx_parallel;
  logic [BITS-1:0] out_rx_data;
  logic            out_rx_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BITS-1:0] sb[$];

  serial_word_feeder #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_wr          (in_wr),
    .in_wr_data     (in_wr_data),
    .out_full       (out_full),
    .out_empty      (out_empty),
    .out_level      (out_level),
    .out_overflow   (out_overflow),
    .out_parallel   (out_parallel),
    .out_enable     (out_enable),
    .in_next_word   (in_next_word),
    .in_ready       (in_ready),
    .in_rx_parallel (in_rx_parallel),
    .out_rx_data    (out_rx_data),
    .out_rx_valid   (out_rx_valid)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (out_enable !== 1'b0 || out_empty !== 1'b1 || out_full !== 1'b0 ||
        out_level !== '0 || out_parallel !== '0 || out_rx_data !== '0 ||
        out_rx_valid !== 1'b0 || out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s: en=%b empty=%b full=%b level=%0d par=%h rx=%h rxv=%b ovf=%b, required en=0 empty=1 full=0 level=0 par=00 rx=00 rxv=0 ovf=0",
               tag, out_enable, out_empty, out_full, out_level, out_parallel,
               out_rx_data, out_rx_valid, out_overflow);
    end
  endtask

  // One host write; expected overflow and level come from the scoreboard.
  task automatic write_word(input logic [BITS-1:0] d);
    bit was_full;
    was_full   = (sb.size() == DEPTH);
    in_wr      = 1'b1;
    in_wr_data = d;
    if (!was_full) sb.push_back(d);
    tick();
    in_wr = 1'b0;
    n_checks++;
    if (out_overflow !== was_full) begin
      n_fail++;
      $display("[TB] FAIL write_overflow: got %b required %b", out_overflow, was_full);
    end
    n_checks++;
    if (int'(out_level) !== sb.size()) begin
      n_fail++;
      $display("[TB] FAIL write_level: got %0d required %0d", out_level, sb.size());
    end
  endtask

  // Emulated serial transfer: wait for enable, check head, pop with a level held `hold` cycles.
  task automatic serve(input int hold);
    int n;
    logic [BITS-1:0] exp;
    n = 0;
    while (out_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (out_enable !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL serve_enable: got enable=%b queued=%0d required enable=1 with words queued",
               out_enable, sb.size());
      return;
    end
    exp = sb.pop_front();
    n_checks++;
    if (out_parallel !== exp) begin
      n_fail++;
      $display("[TB] FAIL head_word: got %h required %h", out_parallel, exp);
    end
    in_next_word   = 1'b1;
    in_rx_parallel = exp;
    tick();
    n_checks++;
    if (out_rx_valid !== 1'b1 || out_rx_data !== exp) begin
      n_fail++;
      $display("[TB] FAIL rx_capture: got valid=%b data=%h required valid=1 data=%h",
               out_rx_valid, out_rx_data, exp);
    end
    n_checks++;
    if (int'(out_level) !== sb.size() || out_enable !== (sb.size() != 0)) begin
      n_fail++;
      $display("[TB] FAIL pop_level: got level=%0d en=%b required level=%0d en=%b",
               out_level, out_enable, sb.size(), sb.size() != 0);
    end
    for (int i = 1; i < hold; i++) begin
      tick();
      n_checks++;
      if (out_rx_valid !== 1'b0 || int'(out_level) !== sb.size()) begin
        n_fail++;
        $display("[TB] FAIL held_next_word: got valid=%b level=%0d required valid=0 level=%0d",
                 out_rx_valid, out_level, sb.size());
      end
    end
    in_next_word = 1'b0;
    tick();
    n_checks++;
    if (out_rx_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rx_pulse_end: got %b required 0", out_rx_valid);
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b0;
    in_wr = 1'b0; in_wr_data = '0; in_next_word = 1'b0;
    in_ready = 1'b1; in_rx_parallel = '0;
    #3;
    check_reset_values("reset_initial");
    tick();
    in_rst = 1'b1;
    tick();
    check_reset_values("reset_released");
  endtask

  task automatic test_loopback();
    write_word(8'hA5);
    n_checks++;
    if (out_enable !== 1'b0 || out_parallel !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL latency_first: got en=%b par=%h required en=0 par=a5", out_enable, out_parallel);
    end
    write_word(8'h3C);
    n_checks++;
    if (out_enable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL latency_enable: got %b required 1", out_enable);
    end
    serve(1);
    serve(1);
    tick();
    tick();
    n_checks++;
    if (out_enable !== 1'b0 || out_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_idle: got en=%b empty=%b required en=0 empty=1", out_enable, out_empty);
    end
  endtask

  task automatic test_back_to_back();
    in_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      write_word(BITS'(8'h11 * i));
      if (i == 4) begin
        n_checks++;
        if (out_full !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL full_flag: got %b required 1", out_full);
        end
      end
    end
    tick();
    n_checks++;
    if (out_overflow !== 1'b0 || int'(out_level) !== DEPTH) begin
      n_fail++;
      $display("[TB] FAIL overflow_pulse: got ovf=%b level=%0d required ovf=0 level=%0d",
               out_overflow, out_level, DEPTH);
    end
    in_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) serve(1);
    tick();
  endtask

  task automatic test_held_next_word();
    write_word(8'h5A);
    write_word(8'hC3);
    serve(3);
    serve(1);
    tick();
  endtask

  task automatic test_write_and_pop();
    logic [BITS-1:0] exp;
    int n;
    write_word(8'hD1);
    write_word(8'hD2);
    n = 0;
    while (out_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    exp            = sb.pop_front();
    sb.push_back(8'hD3);
    in_wr          = 1'b1;
    in_wr_data     = 8'hD3;
    in_next_word   = 1'b1;
    in_rx_parallel = exp;
    tick();
    in_wr = 1'b0;
    n_checks++;
    if (int'(out_level) !== 2 || out_rx_valid !== 1'b1 || out_rx_data !== exp ||
        out_parallel !== sb[0]) begin
      n_fail++;
      $display("[TB] FAIL write_pop_same: got level=%0d rxv=%b rx=%h head=%h required level=2 rxv=1 rx=%h head=%h",
               out_level, out_rx_valid, out_rx_data, out_parallel, exp, sb[0]);
    end
    in_next_word = 1'b0;
    tick();
    serve(1);
    serve(1);
    tick();
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) write_word(BITS'($urandom_range(0, 255)));
      for (int i = 0; i < DEPTH; i++) serve(1);
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    write_word(8'h77);
    write_word(8'h88);
    n = 0;
    while (out_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    #2;
    in_rst = 1'b0;
    #1;
    check_reset_values("reset_mid_run");
    sb.delete();
    tick();
    in_rst = 1'b1;
    tick();
    tick();
    check_reset_values("after_mid_run_reset");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_held_next_word();
    test_write_and_pop();
    test_wrap();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
